// File: rtl/cpu_if_prefetch.sv
// Instruction-fetch stage: sequential IMEM fetch into a prefetch FIFO, redirect/bubble handling, window faults.
// Optional perf counters (perf_stall/perf_flush) are built when IF_PERF_CNT_EN is defined.
module cpu_if_prefetch #(
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        DEPTH        = 4,
  parameter int unsigned        PC_STEP      = 4,
  parameter int unsigned        FLUSH_CYCLES = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] imem_base,
  input  logic [ADDR_W-1:0] imem_high,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_ir,
  output logic              if_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  // Repeated redirects while IMEM is slow can stack stale responses beyond DEPTH.
  localparam int unsigned DROP_W = CNT_W + 3;
  localparam int unsigned BUB_W  = 3;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [BUB_W-1:0]  bubble_q, bubble_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [ADDR_W-1:0] fifo_pc_q  [DEPTH];
  logic [DATA_W-1:0] fifo_ir_q  [DEPTH];
  logic              fifo_flt_q [DEPTH];
  logic [ADDR_W-1:0] tag_pc_q   [DEPTH];

  logic              in_win, credit_ok, may_issue, issue;
  logic              fault_push, rsp_keep, rsp_drop;
  logic              fifo_push, fifo_pop;
  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_ir;
  logic              push_flt;

  // Issue credit, window check and FIFO push/pop qualification.
  always_comb begin
    in_win     = (fetch_pc_q >= imem_base) && (fetch_pc_q <= imem_high);
    inflight   = {1'b0, count_q} + {1'b0, outst_q};
    credit_ok  = inflight < (CNT_W+1)'(DEPTH);
    may_issue  = rst && !halted_q && (bubble_q == '0) && !redirect_valid && credit_ok;
    imem_req   = may_issue && in_win;
    imem_addr  = fetch_pc_q;
    issue      = imem_req && imem_gnt;
    fault_push = may_issue && !in_win && (outst_q == '0);
    rsp_keep   = imem_rvalid && (drop_q == '0);
    rsp_drop   = imem_rvalid && (drop_q != '0);
    if_valid   = (count_q != '0);
    fifo_pop   = if_valid && if_ready && !redirect_valid;
    fifo_push  = !redirect_valid && (rsp_keep || fault_push);
    push_pc    = rsp_keep ? tag_pc_q[tag_rd_q] : fetch_pc_q;
    push_ir    = rsp_keep ? imem_rdata : '0;
    push_flt   = !rsp_keep;
  end

  // Head entry drives decode; data is forced to zero when empty or faulted.
  always_comb begin
    if_pc    = if_valid ? fifo_pc_q[rd_ptr_q] : '0;
    if_fault = if_valid && fifo_flt_q[rd_ptr_q];
    if_ir    = (if_valid && !fifo_flt_q[rd_ptr_q]) ? fifo_ir_q[rd_ptr_q] : '0;
  end

  // Next-state: redirect overrides everything else in the same cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    bubble_d   = bubble_q;
    halted_d   = halted_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      bubble_d   = BUB_W'(FLUSH_CYCLES);
      count_d    = '0;
      outst_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      drop_d     = drop_q + DROP_W'(outst_q) - DROP_W'(imem_rvalid);
    end else begin
      if (bubble_q != '0) bubble_d = bubble_q - BUB_W'(1);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        tag_wr_d   = tag_wr_q + PTR_W'(1);
      end
      if (fault_push) halted_d = 1'b1;
      if (rsp_keep)   tag_rd_d = tag_rd_q + PTR_W'(1);
      if (rsp_drop)   drop_d   = drop_q - DROP_W'(1);
      if (fifo_push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      outst_d = outst_q + CNT_W'(issue) - CNT_W'(rsp_keep);
      count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      bubble_q   <= '0;
      halted_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      bubble_q   <= bubble_d;
      halted_q   <= halted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc_q[wr_ptr_q]  <= push_pc;
      fifo_ir_q[wr_ptr_q]  <= push_ir;
      fifo_flt_q[wr_ptr_q] <= push_flt;
    end
    if (issue) tag_pc_q[tag_wr_q] <= fetch_pc_q;
  end

  // Credit accounting must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst && fifo_push && !fifo_pop) assert (count_q != CNT_W'(DEPTH));
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (if_valid && !if_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      if (redirect_valid && (perf_flush != 32'hFFFF_FFFF))        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_if_prefetch.sv
// Directed bench for cpu_if_prefetch with a variable-latency in-order IMEM model.
module tb_cpu_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_base;
  logic [31:0] imem_high;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_ir;
  logic        if_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int checks   = 0;
  int failures = 0;
  int cn       = 0;
  int lat      = 1;

  always #5 clk = ~clk;

  cpu_if_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_base      (imem_base),
    .imem_high      (imem_high),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_ir          (if_ir),
    .if_fault       (if_fault)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  // IMEM model: word = 0xC0000000 | addr, returned in order after lat cycles.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  int   mcyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      rsp_t r;
      mcyc = mcyc + 1;
      if (imem_req && imem_gnt) begin
        r.addr = imem_addr;
        r.due  = mcyc + lat - 1;
        rq.push_back(r);
      end
      if (rq.size() != 0 && rq[0].due <= mcyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= 32'hC000_0000 | rq[0].addr;
        void'(rq.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cn, obs, exp);
    end
  endtask

  // Advance to the negedge that starts cycle n (cycle 0 = reset release).
  task automatic go(input int n);
    while (cn < n) begin
      @(negedge clk);
      cn++;
    end
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_base = 32'h0; imem_high = 32'hFF; imem_gnt = 1'b1; if_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc",    if_pc,    0);
    chk("rst_ir",    if_ir,    0);
    chk("rst_fault", if_fault, 0);
`ifdef IF_PERF_CNT_EN
    chk("rst_pstall", perf_stall, 0);
    chk("rst_pflush", perf_flush, 0);
`endif

    // Streaming from RESET_PC with a 1-cycle IMEM.
    @(negedge clk); rst = 1'b1; cn = 0; #1;
    chk("c0_req",  imem_req,  1);
    chk("c0_addr", imem_addr, 32'h0);
    go(1); #1;
    chk("c1_valid", if_valid,  0);
    chk("c1_addr",  imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      go(2 + k); #1;
      chk("seq_valid", if_valid, 1);
      chk("seq_pc",    if_pc,    32'(4 * k));
      chk("seq_ir",    if_ir,    32'hC000_0000 | 32'(4 * k));
    end

    // Decode stall: FIFO fills to DEPTH, fetch stops, nothing lost.
    go(6); if_ready = 1'b0; #1;
    go(15); #1;
    chk("stall_req",   imem_req,  0);
    chk("stall_valid", if_valid,  1);
    chk("stall_pc",    if_pc,     32'h10);
    chk("stall_addr",  imem_addr, 32'h20);
    go(16); if_ready = 1'b1; #1;
    chk("resume_req", imem_req, 0);
    chk("resume_pc",  if_pc,    32'h10);
    for (int k = 1; k < 6; k++) begin
      go(16 + k); #1;
      chk("resume_seq_valid", if_valid, 1);
      chk("resume_seq_pc",    if_pc,    32'(16 + 4 * k));
    end

    // Grant withheld for 5 cycles: address held, one fetch per grant afterwards.
    go(22); imem_gnt = 1'b0; #1;
    chk("gnt_addr22", imem_addr, 32'h34);
    chk("gnt_pc22",   if_pc,     32'h28);
    go(25); #1;
    chk("gnt_valid25", if_valid,  0);
    chk("gnt_req25",   imem_req,  1);
    chk("gnt_addr25",  imem_addr, 32'h34);
    go(26); #1;
    chk("gnt_addr26", imem_addr, 32'h34);
    go(27); imem_gnt = 1'b1; lat = 3; #1;
    chk("gnt_req27",  imem_req,  1);
    chk("gnt_addr27", imem_addr, 32'h34);
    go(28); #1;
    chk("gnt_addr28", imem_addr, 32'h38);

    // Redirect to 0x40 with two responses in flight.
    go(29); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("redir_req", imem_req, 0);
    go(30); redirect_valid = 1'b0; #1;
    chk("bub1_req",   imem_req, 0);
    chk("bub1_valid", if_valid, 0);
    go(31); #1;
    chk("bub2_req",   imem_req, 0);
    chk("bub2_valid", if_valid, 0);
    go(32); #1;
    chk("resume_req32",  imem_req,  1);
    chk("resume_addr32", imem_addr, 32'h40);
    go(35); #1;
    chk("stale_valid35", if_valid, 0);
    go(36); #1;
    chk("redir_valid36", if_valid, 1);
    chk("redir_pc36",    if_pc,    32'h40);
    chk("redir_ir36",    if_ir,    32'hC000_0040);

    // Walk off the end of the window at 0x100.
    go(37); redirect_valid = 1'b1; redirect_pc = 32'hF0; imem_high = 32'hFC; lat = 1; #1;
    chk("redir2_req", imem_req, 0);
    go(38); redirect_valid = 1'b0; #1;
    chk("redir2_valid", if_valid, 0);
    go(40); #1;
    chk("win_req40",  imem_req,  1);
    chk("win_addr40", imem_addr, 32'hF0);
    go(42); #1; chk("win_pc42", if_pc, 32'hF0);
    go(43); #1; chk("win_pc43", if_pc, 32'hF4);
    go(44); #1;
    chk("win_pc44",  if_pc,    32'hF8);
    chk("win_req44", imem_req, 0);
    go(45); #1;
    chk("win_pc45",    if_pc,    32'hFC);
    chk("win_fault45", if_fault, 0);
    chk("win_req45",   imem_req, 0);
    go(46); if_ready = 1'b0; #1;
    chk("flt_valid", if_valid, 1);
    chk("flt_fault", if_fault, 1);
    chk("flt_pc",    if_pc,    32'h100);
    chk("flt_ir",    if_ir,    32'h0);
    go(49); #1;
    chk("halt_req",   imem_req, 0);
    chk("halt_fault", if_fault, 1);
    chk("halt_pc",    if_pc,    32'h100);
    go(50); if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0; #1;
    chk("redir3_req", imem_req, 0);
    go(51); redirect_valid = 1'b0; #1;
    chk("redir3_valid", if_valid, 0);
    chk("redir3_fault", if_fault, 0);
    chk("redir3_req51", imem_req, 0);
    go(53); #1;
    chk("redir3_req53",  imem_req,  1);
    chk("redir3_addr53", imem_addr, 32'h0);

`ifdef IF_PERF_CNT_EN
    chk("perf_stall", perf_stall, 14);
    chk("perf_flush", perf_flush, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_if_prefetch.md
Name: cpu_if_prefetch

Overview:
Parametrised next-generation instruction-fetch stage for the KH32/KH16 cores.
- Issues sequential fetches to IMEM over a req/gnt + rvalid interface and buffers returned words with their PCs in a DEPTH-entry prefetch FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Handles redirects (branch/flush) with configurable bubble insertion, and flags fetches outside the IMEM address window as faults instead of stalling forever.

Parameters:
- DATA_W, 32, instruction width (32 for KH32, 16 for KH16).
- ADDR_W, 32, PC/address width.
- DEPTH, 4, prefetch FIFO entries; power of 2, ≥2.
- PC_STEP, 4, PC increment per fetch (2 for KH16).
- FLUSH_CYCLES, 2, issue-blocked cycles after a redirect (0..7).
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  flush pipe and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- imem_base  in  ADDR_W  lowest legal fetch address (inclusive).
- imem_high  in  ADDR_W  highest legal fetch address (inclusive).
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; equals fetch PC.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; responses return in order, latency ≥1.
- imem_rdata  in  DATA_W  read data.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts head; low = stall (load-use, DMEM miss, etc.).
- if_pc  out  ADDR_W  PC of head entry.
- if_ir  out  DATA_W  instruction of head entry; 0 when if_valid=0 or head is a fault.
- if_fault  out  1  head entry is an out-of-window fetch fault.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, bubble=0, halted=0.
  - imem_req=0, if_valid=0, if_pc=0, if_ir=0, if_fault=0.
- Credit: may_issue = !halted && bubble==0 && !redirect_valid && (count + outstanding) < DEPTH.
- Window check (combinational): in_win = (fetch_pc ≥ imem_base) && (fetch_pc ≤ imem_high), unsigned.
- In-window issue:
  - imem_req = may_issue && in_win.
  - On imem_req && imem_gnt: outstanding += 1, PC of the request pushed into the pc-tag queue, fetch_pc += PC_STEP (wraps modulo 2^ADDR_W).
- Out-of-window fault:
  - If may_issue && !in_win && outstanding==0, push one fault entry {pc=fetch_pc, ir=0, fault=1} directly into the FIFO.
  - Set halted=1; no further issue until a redirect.
- Response:
  - On imem_rvalid with drop==0: push {pc=tag head, ir=imem_rdata, fault=0}; outstanding -= 1.
  - On imem_rvalid with drop>0: discard the word; drop -= 1.
- Pop: when if_valid && if_ready, the head is removed. Push and pop in the same cycle are both honoured; count is unchanged.
- Full: credit accounting guarantees a response never arrives to a full FIFO. A push while full is a design error and is asserted in simulation.
- Outputs: driven from the head entry. Valid-to-data latency is 1 cycle after rvalid (registered FIFO write). Minimum fetch-to-decode latency is 2 cycles with 1-cycle IMEM.
- Redirect (highest priority, same cycle):
  - FIFO emptied and tag queue cleared; if_valid=0 next cycle.
  - drop = outstanding (after any same-cycle rvalid is counted as already dropped); outstanding=0.
  - fetch_pc = redirect_pc; halted=0; bubble = FLUSH_CYCLES.
  - imem_req forced 0 in the redirect cycle.
- Bubble: decrements by 1 each cycle while >0. Issue resumes in the cycle bubble reaches 0.
- Simultaneous events:
  - redirect + imem_gnt: the grant is ignored, because req was 0.
  - redirect + if_ready pop: the pop is discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Responses still in flight after reset deassertion are the IMEM's responsibility and are not tracked.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_stall (32 bits) and perf_flush (32 bits), both reset to 0.
  - perf_stall increments each cycle with if_valid && !if_ready.
  - perf_flush increments on each redirect_valid.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, window 0..0xFF, 1-cycle IMEM, if_ready=1 → imem_addr 0,4,8,… on consecutive cycles; if_pc 0,4,8 with matching if_ir; first if_valid 2 cycles after reset release.
- if_ready=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered, imem_req drops to 0, no data lost; resume → PCs continue in order.
- Redirect to 0x40 with 2 responses outstanding, FLUSH_CYCLES=2 → both stale responses dropped; imem_req=0 for 3 cycles (redirect cycle + 2 bubbles); next if_pc=0x40.
- Sequential fetch reaches 0x100 with imem_high=0xFC → single entry if_fault=1, if_pc=0x100, if_ir=0; imem_req stays 0 until redirect to 0x0.
- imem_gnt held low 5 cycles, then high → imem_addr held stable throughout; one fetch per grant; outstanding never exceeds DEPTH minus FIFO count.
- IF_PERF_CNT_EN defined, 7 stall cycles and 3 redirects → perf_stall=7, perf_flush=3.
